// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift unit.
// Macro SHIFT_UNIT_ROTATE_EN makes ops 100/101 count as rotates.
package shift_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Ops that iterate shamt times; everything else completes like LOAD.
    function automatic logic op_counts(input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: r = 1'b1;
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR, OP_ROL:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/result bundle of the sequential shift unit.
interface shift_unit_seq_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int AMT_W   = 5
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                     start;
    logic [SEL_W-1:0]         src_sel;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [2:0]               op;
    logic [AMT_W-1:0]         shamt;
    logic                     busy;
    logic                     done;
    logic [WIDTH-1:0]         result;
    logic                     sel_err;

    modport master (
        output start, src_sel, src_data, op, shamt,
        input  busy, done, result, sel_err
    );

    modport slave (
        input  start, src_sel, src_data, op, shamt,
        output busy, done, result, sel_err
    );
endinterface

// File: rtl/shift_unit_seq_src_select_n.sv
// N-way operand selector; an out-of-range index yields zero and raises err_o.
module src_select_n #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [NUM_SRC*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     err_o
);

    logic hit_s;

    // AND-OR mux over all legal indices; no match leaves the zero default.
    always_comb begin
        data_o = {WIDTH{1'b0}};
        hit_s  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            data_o = data_o | ({WIDTH{sel_i == SEL_W'(k)}} & data_i[k*WIDTH +: WIDTH]);
            hit_s  = hit_s | (sel_i == SEL_W'(k));
        end
        err_o = ~hit_s;
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential 1-bit-per-cycle shifter with operand select and start/done handshake.
// Macro SHIFT_UNIT_ROTATE_EN adds ROR/ROL; otherwise those ops act as LOAD.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int AMT_W   = 5
) (
    input logic            clk,
    input logic            rst_n,
    shift_unit_seq_if.slave bus
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sel_err_q, sel_err_d;
    logic [WIDTH-1:0]   sel_data_s;
    logic               sel_bad_s;

    src_select_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_sel (
        .sel_i  (bus.src_sel),
        .data_i (bus.src_data),
        .data_o (sel_data_s),
        .err_o  (sel_bad_s)
    );

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] r,
                                                    input logic [2:0] op);
        logic [WIDTH-1:0] n;
        case (op)
            OP_SLL:  n = {r[WIDTH-2:0], 1'b0};
            OP_SRL:  n = {1'b0, r[WIDTH-1:1]};
            OP_SRA:  n = {r[WIDTH-1], r[WIDTH-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR:  n = {r[0], r[WIDTH-1:1]};
            OP_ROL:  n = {r[WIDTH-2:0], r[WIDTH-1]};
`endif
            default: n = r;
        endcase
        return n;
    endfunction

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= {WIDTH{1'b0}};
            cnt_q     <= {AMT_W{1'b0}};
            op_q      <= OP_LOAD;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Next state: accept in IDLE/DONE, iterate in SHIFT until the count drains.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_SHIFT;
                    result_d = sel_data_s;
                    err_d    = sel_bad_s;
                    op_d     = bus.op;
                    cnt_d    = op_counts(bus.op) ? bus.shamt : {AMT_W{1'b0}};
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q != {AMT_W{1'b0}}) begin
                    cnt_d    = cnt_q - {{(AMT_W-1){1'b0}}, 1'b1};
                    result_d = shift_step(result_q, op_q);
                end else begin
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are decoded from the upcoming state so they leave flops.
    always_comb begin
        busy_d    = (state_d == S_SHIFT);
        done_d    = (state_d == S_DONE);
        sel_err_d = (state_d == S_DONE) ? err_d : 1'b0;
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sel_err = sel_err_q;
    assign bus.result  = result_q;

endmodule
